// File: rtl/fetch_decode_unit.sv
// Front-end fetch/decode stage: owns the PC, fetches over a req/ack handshake and
// presents registered decoded fields to the immediate extender.
module fetch_decode_unit #(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter logic [3:0] IMM_OPC  = 4'h4,
    parameter logic [3:0] BEQ_OPC  = 4'hC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_o,
    output logic [7:0]  imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [15:0] imem_rdata_i,
    input  logic        stall_i,
    input  logic        redirect_valid_i,
    input  logic [7:0]  redirect_target_i,
    output logic        instr_valid_o,
    output logic [7:0]  pc_out_o,
    output logic [3:0]  opcode_o,
    output logic [5:0]  imm_o,
    output logic [7:0]  addr_o,
    output logic        control_o,
    output logic        beq_o
);

    typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;

    state_t     state_q;
    logic [7:0] pc_q;
    logic       req_q;
    logic [7:0] addr_q;
    logic       valid_q;
    logic [7:0] pc_out_q;
    logic [3:0] opcode_q;
    logic [5:0] imm_q;
    logic [7:0] baddr_q;
    logic       control_q;
    logic       beq_q;

    logic       ack_ok;
    logic [7:0] pc_inc_d;
    logic       unused_rdata;

    // An ack is only meaningful while a request is actually outstanding.
    assign ack_ok       = imem_ack_i & req_q;
    assign pc_inc_d     = pc_q + 8'd1;
    assign unused_rdata = ^imem_rdata_i[11:8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            req_q     <= 1'b0;
            addr_q    <= RESET_PC;
            valid_q   <= 1'b0;
            pc_out_q  <= 8'h00;
            opcode_q  <= 4'h0;
            imm_q     <= 6'h00;
            baddr_q   <= 8'h00;
            control_q <= 1'b0;
            beq_q     <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (redirect_valid_i) begin
                        pc_q    <= redirect_target_i;
                        valid_q <= 1'b0;
                        if (req_q && !imem_ack_i) begin
                            // Request in flight: must keep address until it is acked.
                            state_q <= DISCARD;
                        end else begin
                            state_q <= FETCH;
                            req_q   <= 1'b1;
                            addr_q  <= redirect_target_i;
                        end
                    end else if (ack_ok) begin
                        opcode_q  <= imem_rdata_i[15:12];
                        imm_q     <= imem_rdata_i[5:0];
                        baddr_q   <= imem_rdata_i[7:0];
                        control_q <= (imem_rdata_i[15:12] == IMM_OPC);
                        beq_q     <= (imem_rdata_i[15:12] == BEQ_OPC);
                        pc_out_q  <= pc_q;
                        valid_q   <= 1'b1;
                        pc_q      <= pc_inc_d;
                        req_q     <= 1'b0;
                        state_q   <= HOLD;
                    end else begin
                        req_q  <= 1'b1;
                        addr_q <= pc_q;
                    end
                end
                HOLD: begin
                    if (redirect_valid_i) begin
                        pc_q    <= redirect_target_i;
                        valid_q <= 1'b0;
                        req_q   <= 1'b1;
                        addr_q  <= redirect_target_i;
                        state_q <= FETCH;
                    end else if (!stall_i) begin
                        valid_q <= 1'b0;
                        req_q   <= 1'b1;
                        addr_q  <= pc_q;
                        state_q <= FETCH;
                    end
                end
                DISCARD: begin
                    if (redirect_valid_i) pc_q <= redirect_target_i;
                    if (ack_ok) begin
                        state_q <= FETCH;
                        req_q   <= 1'b1;
                        addr_q  <= redirect_valid_i ? redirect_target_i : pc_q;
                    end
                end
                default: state_q <= FETCH;
            endcase
        end
    end

    assign imem_req_o    = req_q;
    assign imem_addr_o   = addr_q;
    assign instr_valid_o = valid_q;
    assign pc_out_o      = pc_out_q;
    assign opcode_o      = opcode_q;
    assign imm_o         = imm_q;
    assign addr_o        = baddr_q;
    assign control_o     = control_q;
    assign beq_o         = beq_q;

endmodule
